uart_baud_gen: RTL and testbench

Parametrised baud-tick generator for the UART TX/RX datapaths. It produces a 1x bit tick for the transmitter and an OVS-times oversampling tick for the receiver. Each tick comes from an independent divisor, selected from a compile-time preset table or supplied as a custom value at runtime. It adds enable gating, receiver phase re-alignment on start-bit detect, a mid-bit sample strobe, and glitch-free divisor changes applied only at tick boundaries.

---
 rtl/uart_baud_pkg.sv | 51 +++++
 rtl/uart_baud_ctr.sv | 110 +++++++++++
 rtl/uart_baud_gen.sv | 132 +++++++++++++
 tb/tb_uart_baud_gen.sv | 356 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_baud_pkg.sv
// ---------------------------------------------------------------------------
// uart_baud_pkg
// Shared definitions for the UART baud-tick generator:
//   - baud_sel encodings (0..3 preset rates, 4..7 custom divisors)
//   - minimum legal integer divisor
//   - preset divisor computation from the system clock frequency, rounded to
//     the nearest fixed-point value with FRAC_W fractional bits
// The fractional divisor bits only take effect in builds that define
// UART_BAUD_FRAC_EN.
// ---------------------------------------------------------------------------
package uart_baud_pkg;

    typedef enum logic [2:0] {
        SEL_4800   = 3'd0,
        SEL_19200  = 3'd1,
        SEL_115200 = 3'd2,
        SEL_921600 = 3'd3,
        SEL_CUSTOM = 3'd4
    } baud_sel_e;

    // A divisor of 1 would hold the tick high continuously, and 0 is
    // meaningless, so both saturate to this value.
    localparam int unsigned MIN_DIV = 2;

    function automatic longint unsigned baud_rate(input logic [2:0] sel);
        case (sel)
            SEL_4800:   return 64'd4800;
            SEL_19200:  return 64'd19200;
            SEL_115200: return 64'd115200;
            SEL_921600: return 64'd921600;
            default:    return 64'd0;
        endcase
    endfunction

    // Fixed-point divisor (integer part in the MSBs, frac_w fraction bits)
    // for clk_hz / (rate * ovs), rounded to nearest.
    function automatic longint unsigned preset_div(
        input longint unsigned clk_hz,
        input logic [2:0]      sel,
        input longint unsigned ovs,
        input int unsigned     frac_w
    );
        longint unsigned den;
        den = baud_rate(sel) * ovs;
        if (den == 64'd0) begin
            return 64'd0;
        end
        return ((clk_hz << frac_w) + (den >> 1)) / den;
    endfunction

endpackage

// File: rtl/uart_baud_ctr.sv
// ---------------------------------------------------------------------------
// uart_baud_ctr
// One divisor-driven tick counter: counts 0..D-1 and flags the wrap cycle.
// The active divisor is reloaded only on a wrap (so a period is never cut
// short or stretched mid-way), immediately while disabled, and once
// unconditionally on the first clock after reset.
//
// Optional feature: UART_BAUD_FRAC_EN adds a FRAC_W-bit accumulator that
// adds the fractional divisor part at every wrap; a carry-out stretches the
// next period to D+1 cycles. Without the macro the period is always D.
//
// Ports:
//   clk      in   system clock, rising edge
//   reset_n  in   asynchronous active-low reset
//   en       in   enable; low holds count/accumulator at zero, loads divisor
//   clr      in   synchronous clear (phase re-alignment), suppresses wrap
//   req_div  in   requested divisor, integer in the CNT_W MSBs
//   wrap     out  combinational: this cycle ends a period
//   pending  out  requested (clamped) divisor differs from the active one
// ---------------------------------------------------------------------------
module uart_baud_ctr
    import uart_baud_pkg::*;
#(
    parameter int unsigned CNT_W  = 16,
    parameter int unsigned FRAC_W = 4
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic                    en,
    input  logic                    clr,
    input  logic [CNT_W+FRAC_W-1:0] req_div,
    output logic                    wrap,
    output logic                    pending
);

    localparam int unsigned DW = CNT_W + FRAC_W;

    function automatic logic [DW-1:0] clamp_div(input logic [DW-1:0] d);
        logic [DW-1:0] r;
        r = d;
        if (d[DW-1:FRAC_W] < CNT_W'(MIN_DIV)) begin
            r[DW-1:FRAC_W] = CNT_W'(MIN_DIV);
        end
        return r;
    endfunction

    logic [DW-1:0]    act_q;
    logic             init_q;
    logic [CNT_W-1:0] cnt_q;
    logic [DW-1:0]    req_c;
    logic [CNT_W-1:0] div_int;
    logic             extra;
    logic [CNT_W:0]   period;
    logic             last;

    assign req_c = clamp_div(req_div);

    // Before the first load the active register is still zero, so the
    // counter runs from the request directly on that first clock.
    assign div_int = init_q ? act_q[DW-1:FRAC_W] : req_c[DW-1:FRAC_W];
    assign period  = {1'b0, div_int} + {{CNT_W{1'b0}}, extra};
    assign last    = (({1'b0, cnt_q} + (CNT_W+1)'(1)) == period);
    assign wrap    = en && !clr && last;
    assign pending = init_q && (req_c != act_q);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            act_q  <= '0;
            init_q <= 1'b0;
            cnt_q  <= '0;
        end else begin
            init_q <= 1'b1;
            if (!init_q || !en || wrap) begin
                act_q <= req_c;
            end
            if (!en || clr || wrap) begin
                cnt_q <= '0;
            end else begin
                cnt_q <= cnt_q + CNT_W'(1);
            end
        end
    end

`ifdef UART_BAUD_FRAC_EN
    logic [FRAC_W-1:0] acc_q;
    logic              extra_q;
    logic [FRAC_W-1:0] div_frac;
    logic [FRAC_W:0]   acc_sum;

    assign div_frac = init_q ? act_q[FRAC_W-1:0] : req_c[FRAC_W-1:0];
    assign acc_sum  = {1'b0, acc_q} + {1'b0, div_frac};
    assign extra    = extra_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            acc_q   <= '0;
            extra_q <= 1'b0;
        end else if (!en || clr) begin
            acc_q   <= '0;
            extra_q <= 1'b0;
        end else if (wrap) begin
            // Carry-out lengthens the period that starts now.
            {extra_q, acc_q} <= acc_sum;
        end
    end
`else
    assign extra = 1'b0;
`endif

endmodule

// File: rtl/uart_baud_gen.sv
// ---------------------------------------------------------------------------
// uart_baud_gen
// Baud-tick generator: a 1x bit tick for the UART transmitter and an
// OVS-times oversampling tick for the receiver, each from its own divisor
// (preset table derived from CLK_HZ, or a runtime custom value). Provides a
// mid-bit sample strobe, receiver phase re-alignment and glitch-free divisor
// changes applied only at tick boundaries.
//
// Compile option: UART_BAUD_FRAC_EN enables fractional divisors (see
// uart_baud_ctr). Default build uses integer divisors only.
//
// Ports:
//   clk          in   system clock, rising edge
//   reset_n      in   asynchronous active-low reset
//   en           in   generator enable; low holds all counters at zero
//   baud_sel     in   0:4800 1:19200 2:115200 3:921600 4..7:custom
//   cus_tx_div   in   custom TX divisor, integer in the CNT_W MSBs
//   cus_rx_div   in   custom RX divisor, integer in the CNT_W MSBs
//   rx_resync    in   start-bit detect pulse, restarts RX phase
//   tx_tick      out  one pulse per TX bit period
//   rx_tick      out  one pulse per RX oversample period
//   rx_mid       out  rx_tick at oversample index OVS/2-1 (bit centre)
//   cfg_pending  out  a divisor change is requested but not yet applied
// ---------------------------------------------------------------------------
module uart_baud_gen
    import uart_baud_pkg::*;
#(
    parameter int unsigned CLK_HZ = 150_000_000,
    parameter int unsigned OVS    = 16,
    parameter int unsigned CNT_W  = 16,
    parameter int unsigned FRAC_W = 4
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic                    en,
    input  logic [2:0]              baud_sel,
    input  logic [CNT_W+FRAC_W-1:0] cus_tx_div,
    input  logic [CNT_W+FRAC_W-1:0] cus_rx_div,
    input  logic                    rx_resync,
    output logic                    tx_tick,
    output logic                    rx_tick,
    output logic                    rx_mid,
    output logic                    cfg_pending
);

    localparam int unsigned DW    = CNT_W + FRAC_W;
    localparam int unsigned IDX_W = (OVS > 1) ? $clog2(OVS) : 1;

    localparam longint unsigned CLK64 = longint'(CLK_HZ);
    localparam longint unsigned OVS64 = longint'(OVS);

    localparam logic [DW-1:0] TX_P0 = DW'(preset_div(CLK64, SEL_4800,   64'd1, FRAC_W));
    localparam logic [DW-1:0] TX_P1 = DW'(preset_div(CLK64, SEL_19200,  64'd1, FRAC_W));
    localparam logic [DW-1:0] TX_P2 = DW'(preset_div(CLK64, SEL_115200, 64'd1, FRAC_W));
    localparam logic [DW-1:0] TX_P3 = DW'(preset_div(CLK64, SEL_921600, 64'd1, FRAC_W));
    localparam logic [DW-1:0] RX_P0 = DW'(preset_div(CLK64, SEL_4800,   OVS64, FRAC_W));
    localparam logic [DW-1:0] RX_P1 = DW'(preset_div(CLK64, SEL_19200,  OVS64, FRAC_W));
    localparam logic [DW-1:0] RX_P2 = DW'(preset_div(CLK64, SEL_115200, OVS64, FRAC_W));
    localparam logic [DW-1:0] RX_P3 = DW'(preset_div(CLK64, SEL_921600, OVS64, FRAC_W));

    localparam logic [IDX_W-1:0] MID_IDX = IDX_W'(OVS / 2 - 1);

    logic [DW-1:0]    req_tx;
    logic [DW-1:0]    req_rx;
    logic             tx_wrap;
    logic             rx_wrap;
    logic             tx_pend;
    logic             rx_pend;
    logic [IDX_W-1:0] idx_q;

    always_comb begin
        req_tx = cus_tx_div;
        req_rx = cus_rx_div;
        case (baud_sel)
            SEL_4800:   begin req_tx = TX_P0; req_rx = RX_P0; end
            SEL_19200:  begin req_tx = TX_P1; req_rx = RX_P1; end
            SEL_115200: begin req_tx = TX_P2; req_rx = RX_P2; end
            SEL_921600: begin req_tx = TX_P3; req_rx = RX_P3; end
            default:    ;
        endcase
    end

    uart_baud_ctr #(
        .CNT_W  (CNT_W),
        .FRAC_W (FRAC_W)
    ) u_tx_ctr (
        .clk     (clk),
        .reset_n (reset_n),
        .en      (en),
        .clr     (1'b0),
        .req_div (req_tx),
        .wrap    (tx_wrap),
        .pending (tx_pend)
    );

    uart_baud_ctr #(
        .CNT_W  (CNT_W),
        .FRAC_W (FRAC_W)
    ) u_rx_ctr (
        .clk     (clk),
        .reset_n (reset_n),
        .en      (en),
        .clr     (rx_resync),
        .req_div (req_rx),
        .wrap    (rx_wrap),
        .pending (rx_pend)
    );

    // Outputs are registered copies of the wrap decode so they are clean,
    // single-cycle pulses.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            tx_tick     <= 1'b0;
            rx_tick     <= 1'b0;
            rx_mid      <= 1'b0;
            idx_q       <= '0;
            cfg_pending <= 1'b0;
        end else begin
            tx_tick     <= tx_wrap;
            rx_tick     <= rx_wrap;
            rx_mid      <= rx_wrap && (idx_q == MID_IDX);
            // Loads are immediate while disabled, so nothing is pending then.
            cfg_pending <= en && (tx_pend || rx_pend);
            if (!en || rx_resync) begin
                idx_q <= '0;
            end else if (rx_wrap) begin
                idx_q <= idx_q + IDX_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_uart_baud_gen.sv
// Testbench for uart_baud_gen (default parameters: 150 MHz, OVS 16,
// CNT_W 16, FRAC_W 4). Expected tick cycles are queued when stimulus is
// applied and compared against the cycles at which ticks are observed.
module tb_uart_baud_gen;

    localparam int FW = 4;
    localparam int DW = 16 + FW;

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic          en = 1'b0;
    logic [2:0]    baud_sel = 3'd4;
    logic [DW-1:0] cus_tx_div = '0;
    logic [DW-1:0] cus_rx_div = '0;
    logic          rx_resync = 1'b0;
    logic          tx_tick;
    logic          rx_tick;
    logic          rx_mid;
    logic          cfg_pending;

    int cyc = 0;
    int errors = 0;
    int checks = 0;

    int exp_tx[$];
    int exp_rx[$];
    int exp_mid[$];
    int obs_tx[$];
    int obs_rx[$];
    int obs_mid[$];

    uart_baud_gen dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .en          (en),
        .baud_sel    (baud_sel),
        .cus_tx_div  (cus_tx_div),
        .cus_rx_div  (cus_rx_div),
        .rx_resync   (rx_resync),
        .tx_tick     (tx_tick),
        .rx_tick     (rx_tick),
        .rx_mid      (rx_mid),
        .cfg_pending (cfg_pending)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [DW-1:0] fx(input int i, input int f);
        return DW'((i << FW) + f);
    endfunction

    // Advance n cycles, recording the cycle number of every observed pulse.
    task automatic run(input int n);
        repeat (n) begin
            @(negedge clk);
            if (tx_tick) obs_tx.push_back(cyc);
            if (rx_tick) obs_rx.push_back(cyc);
            if (rx_mid)  obs_mid.push_back(cyc);
        end
    endtask

    task automatic clear_queues();
        exp_tx.delete(); exp_rx.delete(); exp_mid.delete();
        obs_tx.delete(); obs_rx.delete(); obs_mid.delete();
    endtask

    // Disable, program custom divisors (loaded immediately while disabled).
    task automatic restart(input logic [DW-1:0] tx_d, input logic [DW-1:0] rx_d);
        en = 1'b0;
        baud_sel = 3'd4;
        cus_tx_div = tx_d;
        cus_rx_div = rx_d;
        run(2);
        clear_queues();
    endtask

    task automatic test_reset();
        int e, a;
        repeat (3) begin
            @(negedge clk);
            checks++;
            if ({tx_tick, rx_tick, rx_mid, cfg_pending} !== 4'b0000) begin
                errors++;
                $display("FAIL reset_outputs: got %b, expected 0000", {tx_tick, rx_tick, rx_mid, cfg_pending});
            end
        end
        cus_tx_div = fx(10, 0);
        cus_rx_div = fx(4, 0);
        reset_n = 1'b1;
        clear_queues();
        run(6);
        a = obs_tx.size() + obs_rx.size() + obs_mid.size();
        checks++;
        if (a !== 0) begin
            errors++;
            $display("FAIL reset_en_low_ticks: got %0d pulses, expected 0", a);
        end
        checks++;
        if (cfg_pending !== 1'b0) begin
            errors++;
            $display("FAIL reset_pending: got %b, expected 0", cfg_pending);
        end
        e = 0;
    endtask

    task automatic test_basic();
        int c0, e, a;
        restart(fx(10, 0), fx(4, 0));
        en = 1'b1;
        c0 = cyc;
        for (int i = 1; i <= 6; i++)  exp_tx.push_back(c0 + 10 * i);
        for (int i = 1; i <= 16; i++) exp_rx.push_back(c0 + 4 * i);
        exp_mid.push_back(c0 + 32);
        run(64);
        while (exp_tx.size() > 0) begin
            e = exp_tx.pop_front();
            a = (obs_tx.size() > 0) ? obs_tx.pop_front() : -1;
            checks++;
            if (a !== e) begin errors++; $display("FAIL basic_tx: tick at %0d, expected %0d", a - c0, e - c0); end
        end
        while (exp_rx.size() > 0) begin
            e = exp_rx.pop_front();
            a = (obs_rx.size() > 0) ? obs_rx.pop_front() : -1;
            checks++;
            if (a !== e) begin errors++; $display("FAIL basic_rx: tick at %0d, expected %0d", a - c0, e - c0); end
        end
        while (exp_mid.size() > 0) begin
            e = exp_mid.pop_front();
            a = (obs_mid.size() > 0) ? obs_mid.pop_front() : -1;
            checks++;
            if (a !== e) begin errors++; $display("FAIL basic_mid: pulse at %0d, expected %0d", a - c0, e - c0); end
        end
        checks++;
        if (obs_tx.size() + obs_rx.size() + obs_mid.size() != 0) begin
            errors++;
            $display("FAIL basic_extra: %0d unexpected pulses, expected 0", obs_tx.size() + obs_rx.size() + obs_mid.size());
        end
    endtask

    task automatic test_frac();
        int c0, e, a;
        restart(fx(10, 8), fx(4, 0));
        en = 1'b1;
        c0 = cyc;
`ifdef UART_BAUD_FRAC_EN
        // Accumulator starts at 0: 10, 10, then alternating 11/10.
        exp_tx.push_back(c0 + 10); exp_tx.push_back(c0 + 20); exp_tx.push_back(c0 + 31);
        exp_tx.push_back(c0 + 41); exp_tx.push_back(c0 + 52); exp_tx.push_back(c0 + 62);
`else
        for (int i = 1; i <= 6; i++) exp_tx.push_back(c0 + 10 * i);
`endif
        run(62);
        while (exp_tx.size() > 0) begin
            e = exp_tx.pop_front();
            a = (obs_tx.size() > 0) ? obs_tx.pop_front() : -1;
            checks++;
            if (a !== e) begin errors++; $display("FAIL frac_tx: tick at %0d, expected %0d", a - c0, e - c0); end
        end
        checks++;
        if (obs_tx.size() != 0) begin
            errors++;
            $display("FAIL frac_extra: %0d unexpected ticks, expected 0", obs_tx.size());
        end
    endtask

    task automatic test_change();
        int c0, e, a;
        restart(fx(10, 0), fx(4, 0));
        en = 1'b1;
        c0 = cyc;
        exp_tx.push_back(c0 + 10); exp_tx.push_back(c0 + 20); exp_tx.push_back(c0 + 30);
        exp_tx.push_back(c0 + 50); exp_tx.push_back(c0 + 70);
        for (int i = 1; i <= 6; i++) exp_rx.push_back(c0 + 4 * i);
        for (int i = 1; i <= 6; i++) exp_rx.push_back(c0 + 24 + 8 * i);
        run(23);
        // TX counter is at 3 here; an interim value is superseded before loading.
        cus_tx_div = fx(15, 0);
        cus_rx_div = fx(8, 0);
        run(2);
        checks++;
        if (cfg_pending !== 1'b1) begin
            errors++;
            $display("FAIL change_pending_high: got %b, expected 1", cfg_pending);
        end
        cus_tx_div = fx(20, 0);
        run(7);
        checks++;
        if (cfg_pending !== 1'b0) begin
            errors++;
            $display("FAIL change_pending_low: got %b, expected 0", cfg_pending);
        end
        run(40);
        while (exp_tx.size() > 0) begin
            e = exp_tx.pop_front();
            a = (obs_tx.size() > 0) ? obs_tx.pop_front() : -1;
            checks++;
            if (a !== e) begin errors++; $display("FAIL change_tx: tick at %0d, expected %0d", a - c0, e - c0); end
        end
        while (exp_rx.size() > 0) begin
            e = exp_rx.pop_front();
            a = (obs_rx.size() > 0) ? obs_rx.pop_front() : -1;
            checks++;
            if (a !== e) begin errors++; $display("FAIL change_rx: tick at %0d, expected %0d", a - c0, e - c0); end
        end
        checks++;
        if (obs_tx.size() + obs_rx.size() != 0) begin
            errors++;
            $display("FAIL change_extra: %0d unexpected ticks, expected 0", obs_tx.size() + obs_rx.size());
        end
    endtask

    task automatic test_resync();
        int c0, e, a;
        restart(fx(10, 0), fx(4, 0));
        en = 1'b1;
        c0 = cyc;
        // Resync takes effect at cycle c0+14, two cycles before the wrap at c0+16.
        exp_rx.push_back(c0 + 4); exp_rx.push_back(c0 + 8); exp_rx.push_back(c0 + 12);
        for (int i = 1; i <= 9; i++) exp_rx.push_back(c0 + 14 + 4 * i);
        exp_mid.push_back(c0 + 14 + 8 * 4);
        run(13);
        rx_resync = 1'b1;
        run(1);
        rx_resync = 1'b0;
        run(36);
        while (exp_rx.size() > 0) begin
            e = exp_rx.pop_front();
            a = (obs_rx.size() > 0) ? obs_rx.pop_front() : -1;
            checks++;
            if (a !== e) begin errors++; $display("FAIL resync_rx: tick at %0d, expected %0d", a - c0, e - c0); end
        end
        while (exp_mid.size() > 0) begin
            e = exp_mid.pop_front();
            a = (obs_mid.size() > 0) ? obs_mid.pop_front() : -1;
            checks++;
            if (a !== e) begin errors++; $display("FAIL resync_mid: pulse at %0d, expected %0d", a - c0, e - c0); end
        end
        checks++;
        if (obs_rx.size() + obs_mid.size() != 0) begin
            errors++;
            $display("FAIL resync_extra: %0d unexpected pulses, expected 0", obs_rx.size() + obs_mid.size());
        end
    endtask

    task automatic test_reset_mid();
        int c0, c1, e, a;
        restart(fx(10, 0), fx(4, 0));
        en = 1'b1;
        c0 = cyc;
        exp_tx.push_back(c0 + 10);
        for (int i = 1; i <= 3; i++) exp_rx.push_back(c0 + 4 * i);
        run(15);
        reset_n = 1'b0;
        repeat (3) begin
            @(negedge clk);
            checks++;
            if ({tx_tick, rx_tick, rx_mid, cfg_pending} !== 4'b0000) begin
                errors++;
                $display("FAIL reset_mid_outputs: got %b, expected 0000", {tx_tick, rx_tick, rx_mid, cfg_pending});
            end
        end
        reset_n = 1'b1;
        c1 = cyc;
        exp_tx.push_back(c1 + 10); exp_tx.push_back(c1 + 20);
        for (int i = 1; i <= 5; i++) exp_rx.push_back(c1 + 4 * i);
        run(20);
        while (exp_tx.size() > 0) begin
            e = exp_tx.pop_front();
            a = (obs_tx.size() > 0) ? obs_tx.pop_front() : -1;
            checks++;
            if (a !== e) begin errors++; $display("FAIL reset_mid_tx: tick at %0d, expected %0d", a - c0, e - c0); end
        end
        while (exp_rx.size() > 0) begin
            e = exp_rx.pop_front();
            a = (obs_rx.size() > 0) ? obs_rx.pop_front() : -1;
            checks++;
            if (a !== e) begin errors++; $display("FAIL reset_mid_rx: tick at %0d, expected %0d", a - c0, e - c0); end
        end
        en = 1'b0;
        clear_queues();
        run(30);
        checks++;
        if (obs_tx.size() + obs_rx.size() + obs_mid.size() != 0) begin
            errors++;
            $display("FAIL disabled_ticks: got %0d pulses, expected 0", obs_tx.size() + obs_rx.size() + obs_mid.size());
        end
    endtask

    task automatic test_min_div();
        int c0, e, a;
        restart(fx(0, 0), fx(1, 0));
        en = 1'b1;
        c0 = cyc;
        for (int i = 1; i <= 6; i++) begin
            exp_tx.push_back(c0 + 2 * i);
            exp_rx.push_back(c0 + 2 * i);
        end
        run(12);
        while (exp_tx.size() > 0) begin
            e = exp_tx.pop_front();
            a = (obs_tx.size() > 0) ? obs_tx.pop_front() : -1;
            checks++;
            if (a !== e) begin errors++; $display("FAIL min_div_tx: tick at %0d, expected %0d", a - c0, e - c0); end
        end
        while (exp_rx.size() > 0) begin
            e = exp_rx.pop_front();
            a = (obs_rx.size() > 0) ? obs_rx.pop_front() : -1;
            checks++;
            if (a !== e) begin errors++; $display("FAIL min_div_rx: tick at %0d, expected %0d", a - c0, e - c0); end
        end
    endtask

    task automatic test_preset();
        int c0, e, a;
        restart(fx(10, 0), fx(4, 0));
        baud_sel = 3'd0;
        run(2);
        clear_queues();
        en = 1'b1;
        c0 = cyc;
        // 150 MHz / 4800 = 31250; 150 MHz / (4800*16) = 1953.125 -> integer 1953.
        exp_tx.push_back(c0 + 31250);
        exp_rx.push_back(c0 + 1953);
        run(31252);
        e = exp_tx.pop_front();
        a = (obs_tx.size() > 0) ? obs_tx.pop_front() : -1;
        checks++;
        if (a !== e) begin errors++; $display("FAIL preset_tx: first tick at %0d, expected %0d", a - c0, e - c0); end
        checks++;
        if (obs_tx.size() != 0) begin
            errors++;
            $display("FAIL preset_tx_extra: %0d unexpected ticks, expected 0", obs_tx.size());
        end
        e = exp_rx.pop_front();
        a = (obs_rx.size() > 0) ? obs_rx.pop_front() : -1;
        checks++;
        if (a !== e) begin errors++; $display("FAIL preset_rx: first tick at %0d, expected %0d", a - c0, e - c0); end
        en = 1'b0;
        baud_sel = 3'd4;
    endtask

    initial begin
        test_reset();
        test_basic();
        test_frac();
        test_change();
        test_resync();
        test_reset_mid();
        test_min_div();
        test_preset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
